muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port START  input  1  request to begin an operation.
REQ-005 SHALL have port ALU_OPCODE  input  5  M-extension op, using the shared opcode macros MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-006 SHALL have ports DATA1 and DATA2  input  32 each  rs1/rs2 operands, sampled only at the accepting edge.
REQ-007 SHALL have port FLUSH  input  1  abort request from the pipeline.
REQ-008 SHALL have port BUSY  output  1  high while an operation is in flight; the pipeline stalls on it.
REQ-009 SHALL have port DONE  output  1  registered one-cycle result-valid pulse.
REQ-010 SHALL have port RESULT  output  32  registered result; holds its value until the next DONE.

Function
REQ-011 SHALL use states IDLE, MUL, DIV, FIX and DONE; BUSY SHALL be high exactly in MUL, DIV and FIX.
REQ-012 SHALL accept START only in IDLE or DONE; accepting edge k latches operands and opcode and moves to MUL (any non-divide opcode) or DIV.
REQ-013 MUL family timing: DONE=1 for the cycle after edge k+1.
REQ-014 MUL family arithmetic: full 64-bit product; MUL low 32 bits; MULH signed x signed high; MULHSU signed DATA1 x unsigned DATA2 high; MULHU unsigned x unsigned high.
REQ-015 Non-M opcodes SHALL complete via the MUL path with RESULT=0.
REQ-016 DIV family SHALL use restoring division on operand magnitudes: 32 iterations (edges k+1..k+32) driven by a 6-bit down-counter, then FIX applies signs at edge k+33; DONE=1 for the cycle after edge k+33.
REQ-017 Sign rules: quotient is negative iff the signed operand signs differ; remainder takes the dividend's sign; DIVU/REMU apply no correction.
REQ-018 Divisor zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give DATA1.
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
REQ-020 DONE state SHALL return to IDLE at the next edge unless START is accepted there (back-to-back issue).
REQ-021 START outside IDLE/DONE SHALL be ignored.
REQ-022 FLUSH high at an edge SHALL force IDLE and suppress DONE; RESULT is unchanged.
REQ-023 FLUSH SHALL take priority over a simultaneous START.

Reset
REQ-024 RESET SHALL immediately, without a clock, force state IDLE, BUSY=0, DONE=0, RESULT=0, counter=0 and operand registers=0, including in the middle of an operation.
REQ-025 After RESET deasserts, the first rising edge SHALL be able to accept START.

Configuration
REQ-026 With MDU_EARLY_OUT_EN defined, divide-by-zero and signed-overflow cases SHALL skip iteration and go directly to DONE; DONE=1 for the cycle after edge k+1.
REQ-027 Without MDU_EARLY_OUT_EN, all DIV family ops SHALL take the full REQ-016 latency; results are identical either way.

Structure
REQ-028 Opcode macros and the state encodings SHALL live in the shared definitions file.
REQ-029 The iterative divider datapath (remainder/quotient shift registers, counter) SHALL be the sub-module div_core; muldiv_seq holds the FSM, multiplier, sign fix-up and result selection.

Verification
REQ-030 MUL 7 x 0xFFFFFFFD accepted at edge k -> RESULT 0xFFFFFFEB, DONE only in the cycle after k+1.
REQ-031 Operands 0xFFFFFFFF, 0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, DONE after k+33, BUSY high for 33 cycles.
REQ-033 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; latency k+1 with the macro, k+33 without.
REQ-034 FLUSH at iteration 10 of DIVU -> no DONE, BUSY low next cycle; a following DIVU 10/3 -> 3.
REQ-035 RESET pulsed mid-divide with CLK stopped -> BUSY, DONE and RESULT go to 0 immediately.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: M-extension opcodes,
// FSM state encodings and small opcode-decode helpers.
package muldiv_seq_pkg;

    localparam int MDU_XLEN = 32;

    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    function automatic logic isDivOp(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic isSignedDiv(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic isRemOp(input logic [4:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Cases whose result is fixed without iterating: divide by zero and signed overflow.
    function automatic logic divSpecial(input logic [4:0] op,
                                        input logic [MDU_XLEN-1:0] a,
                                        input logic [MDU_XLEN-1:0] b);
        return (b == '0) ||
               (isSignedDiv(op) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Pipeline-facing handshake of muldiv_seq; the pipeline is master, the unit is slave.
interface muldiv_seq_if
    import muldiv_seq_pkg::*;
    #(parameter int XLEN = MDU_XLEN);

    logic            START;
    logic [4:0]      ALU_OPCODE;
    logic [XLEN-1:0] DATA1;
    logic [XLEN-1:0] DATA2;
    logic            FLUSH;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    modport master (output START, ALU_OPCODE, DATA1, DATA2, FLUSH,
                    input  BUSY, DONE, RESULT);

    modport slave  (input  START, ALU_OPCODE, DATA1, DATA2, FLUSH,
                    output BUSY, DONE, RESULT);

endinterface

// File: rtl/muldiv_seq_div_core.sv
// Restoring unsigned divider: one quotient bit per clock, XLEN steps from a
// 6-bit down-counter. Operands arrive as magnitudes; signs are fixed by the caller.
module div_core
    import muldiv_seq_pkg::*;
    #(parameter int XLEN = MDU_XLEN)
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quot,
    output logic [XLEN-1:0] o_rem,
    output logic            o_last
);

    logic [5:0]      r_count;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;

    // The partial remainder stays below the divisor, so the shifted value fits XLEN+1 bits.
    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_div   <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= 6'(XLEN);
            r_quot  <= i_dividend;
            r_rem   <= '0;
            r_div   <= i_divisor;
        end else if (r_count != '0) begin
            r_count <= r_count - 6'd1;
            if (!w_diff[XLEN]) begin
                r_rem  <= w_diff[XLEN-1:0];
                r_quot <= {r_quot[XLEN-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[XLEN-1:0];
                r_quot <= {r_quot[XLEN-2:0], 1'b0};
            end
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_last = (r_count == 6'd1);

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension unit: single-cycle-issue multiplier plus iterative divider.
// Optional MDU_EARLY_OUT_EN skips iteration for divide-by-zero and signed overflow.
module muldiv_seq
    import muldiv_seq_pkg::*;
    #(parameter int XLEN = MDU_XLEN)
(
    input  logic         CLK,
    input  logic         RESET,
    muldiv_seq_if.slave  bus
);

    logic [2:0]              r_state;
    logic [4:0]              r_op;
    logic [XLEN-1:0]         r_a;
    logic [XLEN-1:0]         r_b;
    logic [XLEN-1:0]         r_result;

    logic                    w_accept;
    logic                    w_isDiv;
    logic                    w_skip;
    logic                    w_load;
    logic [XLEN-1:0]         w_magA;
    logic [XLEN-1:0]         w_magB;
    logic [XLEN-1:0]         w_quot;
    logic [XLEN-1:0]         w_rem;
    logic                    w_last;
    logic signed [XLEN:0]    w_aExt;
    logic signed [XLEN:0]    w_bExt;
    logic signed [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]         w_mulRes;
    logic                    w_qNeg;
    logic                    w_rNeg;
    logic [XLEN-1:0]         w_divRes;

    assign w_accept = bus.START && !bus.FLUSH && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_isDiv  = isDivOp(bus.ALU_OPCODE);

`ifdef MDU_EARLY_OUT_EN
    assign w_skip = divSpecial(bus.ALU_OPCODE, bus.DATA1, bus.DATA2);
`else
    assign w_skip = 1'b0;
`endif

    assign w_load = w_accept && w_isDiv && !w_skip;
    assign w_magA = (isSignedDiv(bus.ALU_OPCODE) && bus.DATA1[XLEN-1]) ? -bus.DATA1 : bus.DATA1;
    assign w_magB = (isSignedDiv(bus.ALU_OPCODE) && bus.DATA2[XLEN-1]) ? -bus.DATA2 : bus.DATA2;

    div_core #(.XLEN(XLEN)) u_divCore (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_load     (w_load),
        .i_clear    (bus.FLUSH),
        .i_dividend (w_magA),
        .i_divisor  (w_magB),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_last     (w_last)
    );

    // One extra sign bit per operand lets a single signed multiply cover all four variants.
    assign w_aExt = {((r_op == OP_MULH) || (r_op == OP_MULHSU)) && r_a[XLEN-1], r_a};
    assign w_bExt = {(r_op == OP_MULH) && r_b[XLEN-1], r_b};
    assign w_prod = (2*XLEN)'(w_aExt) * (2*XLEN)'(w_bExt);

    always_comb begin
        w_mulRes = '0;
        case (r_op)
            OP_MUL:                       w_mulRes = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_mulRes = w_prod[2*XLEN-1:XLEN];
            default:                      w_mulRes = '0;
        endcase
    end

    assign w_qNeg = isSignedDiv(r_op) && (r_a[XLEN-1] ^ r_b[XLEN-1]);
    assign w_rNeg = isSignedDiv(r_op) && r_a[XLEN-1];

    always_comb begin
        w_divRes = '0;
        if (r_b == '0)
            w_divRes = isRemOp(r_op) ? r_a : '1;
        else if (divSpecial(r_op, r_a, r_b))
            w_divRes = isRemOp(r_op) ? '0 : r_a;
        else if (isRemOp(r_op))
            w_divRes = w_rNeg ? -w_rem : w_rem;
        else
            w_divRes = w_qNeg ? -w_quot : w_quot;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else if (bus.FLUSH) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op <= bus.ALU_OPCODE;
                        r_a  <= bus.DATA1;
                        r_b  <= bus.DATA2;
                        if (!w_isDiv)
                            r_state <= S_MUL;
                        else if (w_skip)
                            r_state <= S_FIX;
                        else
                            r_state <= S_DIV;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_result <= w_mulRes;
                    r_state  <= S_DONE;
                end
                S_DIV: begin
                    if (w_last)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_divRes;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.BUSY   = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
    assign bus.DONE   = (r_state == S_DONE);
    assign bus.RESULT = r_result;

endmodule
